// File: rtl/fsml_behavioral.sv
// Moore detector for two or more consecutive 1s on a serial bit stream.
// Binary-encoded state register; Dout is registered and tracks state == TWO.
module fsml_behavioral (
  output logic Dout,
  input  logic Clock,
  input  logic Reset,
  input  logic Din
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONE  = 2'b01,
    TWO  = 2'b10
  } state_t;

  state_t r_state;
  logic   r_dout;

  // r_dout is loaded with the decode of the next state, so it always equals (r_state == TWO)
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_dout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= Din ? ONE : IDLE;
          r_dout  <= 1'b0;
        end
        ONE: begin
          r_state <= Din ? TWO : IDLE;
          r_dout  <= Din;
        end
        TWO: begin
          r_state <= Din ? TWO : IDLE;
          r_dout  <= Din;
        end
        default: begin
          r_state <= IDLE;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

  assign Dout = r_dout;

endmodule

// File: tb/tb_fsml_behavioral.sv
// Bench for fsml_behavioral: directed steps then random Din/Reset, checked
// against a run-length model (Dout expected iff the current run of 1s is >= 2).
module tb_fsml_behavioral;

  logic Dout, Clock, Reset, Din;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   run    = 0;

  fsml_behavioral dut (
    .Dout  (Dout),
    .Clock (Clock),
    .Reset (Reset),
    .Din   (Din)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  // Length of the current run of sampled 1s, saturated at 2.
  task automatic upd();
    if (Reset)    run = 0;
    else if (Din) run = (run < 2) ? run + 1 : 2;
    else          run = 0;
  endtask

  task automatic chk(input string tag);
    logic exp;
    exp = (run >= 2);
    n_chk++;
    assert (Dout === exp) else begin
      n_fail++;
      $error("FAIL %s: Dout=%b expected %b", tag, Dout, exp);
    end
  endtask

  task automatic step(input logic d, input logic r, input string tag);
    @(negedge Clock);
    Din   = d;
    Reset = r;
    @(posedge Clock);
    upd();
    #1 chk(tag);
  endtask

  // Flip Din for 5 ns well inside a cycle, restore it before the next edge.
  task automatic glitch(input string tag);
    logic base;
    base = Din;
    #3 Din = ~base;
    #5 Din = base;
    @(posedge Clock);
    upd();
    #1 chk(tag);
  endtask

  task automatic rst_pulse(input string tag);
    #3 Reset = 1'b1;
    #5 Reset = 1'b0;
    @(posedge Clock);
    upd();
    #1 chk(tag);
  endtask

  initial begin
    Reset = 1'b1;
    Din   = 1'b0;
    @(posedge Clock); upd(); #1 chk("rst_edge10");
    Din = 1'b1;
    @(posedge Clock); upd(); #1 chk("rst_edge30");
    #4 Reset = 1'b0;
    #1 chk("rst_released");

    step(1'b1, 1'b0, "single_1");
    step(1'b0, 1'b0, "single_0");

    step(1'b1, 1'b0, "run_e1");
    step(1'b1, 1'b0, "run_e2");
    step(1'b1, 1'b0, "run_e3");
    step(1'b0, 1'b0, "run_fall");

    step(1'b1, 1'b0, "alt_1a");
    step(1'b0, 1'b0, "alt_0a");
    step(1'b1, 1'b0, "alt_1b");
    step(1'b0, 1'b0, "alt_0b");
    step(1'b1, 1'b0, "alt_1c");

    step(1'b1, 1'b0, "mid_two");
    step(1'b1, 1'b1, "mid_rst");
    step(1'b1, 1'b0, "mid_post1");
    step(1'b1, 1'b0, "mid_post2");

    rst_pulse("rst_between_edges");

    glitch("glitch_low_in_two");
    step(1'b0, 1'b0, "to_idle");
    glitch("glitch_high_in_idle");
    step(1'b1, 1'b0, "after_glitch");

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(1, 0)), 1'($urandom_range(15, 0) == 0), "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
